// File: rtl/lives_drawer.sv
// lives_drawer: draws a row of life icons, keeps the life count and raises game over.
// Optional macro LIVES_DRAWER_BLINK_EN adds a BLINK state that flashes the icon just lost.
//
// Ports:
//   clk, reset (sync, active-high)
//   pixelX, pixelY : current pixel
//   startOfFrame   : one pulse per frame
//   lifeLost       : player hit
//   livesReset     : new game
//   lifeRequest    : registered, pixel is on a drawn icon
//   lifeRGB        : registered icon colour, 0 when not requesting
//   livesCount     : remaining lives
//   gameOver       : high while in OVER
module lives_drawer #(
  parameter int          MAX_LIVES    = 5,
  parameter int          X0           = 16,
  parameter int          Y0           = 16,
  parameter int          PITCH        = 24,
  parameter int          BLINK_FRAMES = 48,
  parameter logic [7:0]  EDGE_RGB     = 8'h80,
  parameter logic [7:0]  FILL_RGB     = 8'hE0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic        lifeLost,
  input  logic        livesReset,
  output logic        lifeRequest,
  output logic [7:0]  lifeRGB,
  output logic [2:0]  livesCount,
  output logic        gameOver
);

  localparam logic [2:0] MAXL = 3'(MAX_LIVES);

`ifdef LIVES_DRAWER_BLINK_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLINK = 2'd1,
    OVER  = 2'd2
  } state_t;

  // frameCnt needs at least bit 2 for the blink phase
  localparam int FW =
    ($clog2(BLINK_FRAMES) < 3) ? 3 : $clog2(BLINK_FRAMES);
  localparam logic [FW-1:0] FLAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] frameCnt;
  logic [FW-1:0] frameNext;
  logic          blinkVis;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OVER = 2'd2
  } state_t;
`endif

  state_t     state;
  state_t     stateNext;
  logic [2:0] livesNext;
  logic       lossOk;

  assign lossOk   = lifeLost && (livesCount != 3'd0) && (state != OVER);
  assign gameOver = (state == OVER);

`ifdef LIVES_DRAWER_BLINK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      livesCount <= MAXL;
      frameCnt   <= '0;
    end else begin
      state      <= stateNext;
      livesCount <= livesNext;
      frameCnt   <= frameNext;
    end
  end

  // lifeLost outranks startOfFrame: the frame tick is simply dropped
  always_comb begin
    stateNext = state;
    livesNext = livesCount;
    frameNext = frameCnt;
    if (livesReset) begin
      stateNext = IDLE;
      livesNext = MAXL;
      frameNext = '0;
    end else begin
      case (state)
        IDLE: begin
          if (lossOk) begin
            livesNext = livesCount - 3'd1;
            frameNext = '0;
            stateNext = BLINK;
          end
        end
        BLINK: begin
          if (lossOk) begin
            livesNext = livesCount - 3'd1;
            frameNext = '0;
          end else if (startOfFrame) begin
            if (frameCnt == FLAST) begin
              frameNext = '0;
              stateNext = (livesCount == 3'd0) ? OVER : IDLE;
            end else begin
              frameNext = frameCnt + FW'(1);
            end
          end
        end
        OVER: begin
          stateNext = OVER;
        end
        default: begin
          stateNext = IDLE;
        end
      endcase
    end
  end

  assign blinkVis = (state == BLINK) && !frameCnt[2];
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      livesCount <= MAXL;
    end else begin
      state      <= stateNext;
      livesCount <= livesNext;
    end
  end

  always_comb begin
    stateNext = state;
    livesNext = livesCount;
    if (livesReset) begin
      stateNext = IDLE;
      livesNext = MAXL;
    end else begin
      case (state)
        IDLE: begin
          if (lossOk) begin
            livesNext = livesCount - 3'd1;
            stateNext = (livesCount == 3'd1) ? OVER : IDLE;
          end
        end
        OVER: begin
          stateNext = OVER;
        end
        default: begin
          stateNext = IDLE;
        end
      endcase
    end
  end
`endif

  // 12-bit compares so icon bounds near the screen edge cannot wrap
  localparam logic [11:0] TOP = 12'(Y0);

  logic [11:0]          px;
  logic [11:0]          py;
  logic                 inRow;
  logic                 rowRing;
  logic [MAX_LIVES-1:0] inIcon;
  logic [MAX_LIVES-1:0] onRing;
  logic [MAX_LIVES-1:0] shown;
  logic                 hit;
  logic                 ring;

  assign px      = {1'b0, pixelX};
  assign py      = {1'b0, pixelY};
  assign inRow   = (py >= TOP) && (py < TOP + 12'd16);
  assign rowRing = (py < TOP + 12'd2) || (py >= TOP + 12'd14);

  for (genvar k = 0; k < MAX_LIVES; k++) begin : g_icon
    localparam logic [11:0] LX = 12'(X0 + k * PITCH);
    assign inIcon[k] = inRow && (px >= LX) && (px < LX + 12'd16);
    assign onRing[k] = rowRing || (px < LX + 12'd2) ||
                       (px >= LX + 12'd14);
`ifdef LIVES_DRAWER_BLINK_EN
    assign shown[k] = (3'(k) < livesCount) ||
                      ((3'(k) == livesCount) && blinkVis);
`else
    assign shown[k] = (3'(k) < livesCount);
`endif
  end

  assign hit  = (state != OVER) && |(inIcon & shown);
  assign ring = |(inIcon & shown & onRing);

  always_ff @(posedge clk) begin
    if (reset) begin
      lifeRequest <= 1'b0;
      lifeRGB     <= 8'h00;
    end else begin
      lifeRequest <= hit;
      lifeRGB     <= hit ? (ring ? EDGE_RGB : FILL_RGB) : 8'h00;
    end
  end

endmodule

// File: tb/tb_lives_drawer.sv
// tb_lives_drawer: randomized scoreboard bench for lives_drawer.
// Reference model tracks lives/blink/over as plain integers.
module tb_lives_drawer;

  localparam int MAXL  = 5;
  localparam int X0    = 16;
  localparam int Y0    = 16;
  localparam int PITCH = 24;
  localparam int BF    = 48;
  localparam logic [7:0] ERGB = 8'h80;
  localparam logic [7:0] FRGB = 8'hE0;

  logic        clk;
  logic        reset;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        startOfFrame;
  logic        lifeLost;
  logic        livesReset;
  logic        lifeRequest;
  logic [7:0]  lifeRGB;
  logic [2:0]  livesCount;
  logic        gameOver;

  lives_drawer #(
    .MAX_LIVES(MAXL), .X0(X0), .Y0(Y0), .PITCH(PITCH),
    .BLINK_FRAMES(BF), .EDGE_RGB(ERGB), .FILL_RGB(FRGB)
  ) dut (
    .clk(clk), .reset(reset),
    .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .lifeLost(lifeLost),
    .livesReset(livesReset),
    .lifeRequest(lifeRequest), .lifeRGB(lifeRGB),
    .livesCount(livesCount), .gameOver(gameOver)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         req;
    logic [7:0] rgb;
    int         lives;
    bit         over;
    int         tag;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   tagCnt = 0;

  // reference state
  int m_lives;
  bit m_blink;
  int m_frame;
  bit m_over;

  function automatic void pixel_exp(input int x, input int y,
                                    output bit req,
                                    output logic [7:0] rgb);
    int lx;
    int ly;
    bit vis;
    req = 0;
    rgb = 8'h00;
    if (m_over) return;
    ly = y - Y0;
    for (int k = 0; k < MAXL; k++) begin
      lx = x - (X0 + k * PITCH);
      if (lx >= 0 && lx < 16 && ly >= 0 && ly < 16) begin
        vis = (k < m_lives) ||
              (k == m_lives && m_blink && (m_frame % 8) < 4);
        if (vis) begin
          req = 1;
          if (lx < 2 || lx > 13 || ly < 2 || ly > 13) rgb = ERGB;
          else rgb = FRGB;
        end
      end
    end
  endfunction

  function automatic void model_update(input bit rst, input bit sof,
                                       input bit lost, input bit lrst);
    if (rst || lrst) begin
      m_lives = MAXL;
      m_blink = 0;
      m_frame = 0;
      m_over  = 0;
    end else if (lost && m_lives > 0 && !m_over) begin
      m_lives--;
`ifdef LIVES_DRAWER_BLINK_EN
      m_blink = 1;
      m_frame = 0;
`else
      m_over = (m_lives == 0);
`endif
    end else if (m_blink && sof) begin
      if (m_frame == BF - 1) begin
        m_blink = 0;
        m_frame = 0;
        m_over  = (m_lives == 0);
      end else begin
        m_frame++;
      end
    end
  endfunction

  task automatic step(input int x, input int y, input bit sof,
                      input bit lost, input bit lrst, input bit rst);
    exp_t e;
    @(negedge clk);
    pixelX       = 11'(x);
    pixelY       = 11'(y);
    startOfFrame = sof;
    lifeLost     = lost;
    livesReset   = lrst;
    reset        = rst;
    if (rst) begin
      e.req = 0;
      e.rgb = 8'h00;
    end else begin
      pixel_exp(x, y, e.req, e.rgb);
    end
    model_update(rst, sof, lost, lrst);
    e.lives = m_lives;
    e.over  = m_over;
    e.tag   = tagCnt++;
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      vectors++;
      if (lifeRequest !== e.req || lifeRGB !== e.rgb ||
          int'(livesCount) != e.lives || gameOver !== e.over) begin
        miscompares++;
        $display("FAIL vec%0d got req=%0b rgb=%h lives=%0d over=%0b want req=%0b rgb=%h lives=%0d over=%0b",
                 e.tag, lifeRequest, lifeRGB, livesCount, gameOver,
                 e.req, e.rgb, e.lives, e.over);
      end
    end
  end

  task automatic rand_step(input int pLost, input int pLrst,
                           input int pRst);
    int k;
    int x;
    int y;
    k = $urandom_range(0, 6);
    x = X0 + k * PITCH + $urandom_range(0, 23) - 2;
    y = $urandom_range(Y0 - 4, Y0 + 20);
    step(x, y, $urandom_range(0, 3) == 0,
         $urandom_range(1, pLost) == 1,
         $urandom_range(1, pLrst) == 1,
         $urandom_range(1, pRst) == 1);
  endtask

  initial begin
    reset        = 1'b1;
    pixelX       = '0;
    pixelY       = '0;
    startOfFrame = 1'b0;
    lifeLost     = 1'b0;
    livesReset   = 1'b0;
    m_lives = MAXL;
    m_blink = 0;
    m_frame = 0;
    m_over  = 0;

    step(16, 16, 0, 0, 0, 1);
    step(16, 16, 1, 1, 0, 1);
    step(16, 16, 0, 0, 0, 0);
    step(24, 24, 0, 0, 0, 0);
    step(32, 16, 0, 0, 0, 0);
    step(112, 20, 0, 0, 0, 0);
    step(136, 20, 0, 0, 0, 0);
    step(127, 31, 0, 0, 0, 0);
    step(121, 23, 0, 0, 0, 0);

    // one loss, then watch icon 4 through a full blink
    step(112, 20, 1, 1, 0, 0);
    for (int f = 0; f < BF + 4; f++) begin
      step(112, 20, 1, 0, 0, 0);
      step(118, 24, 0, 0, 0, 0);
    end

    // loss mid-blink moves the blink to the next icon
    step(88, 20, 0, 1, 0, 0);
    for (int f = 0; f < 10; f++) step(88, 20, 1, 0, 0, 0);
    step(88, 20, 0, 1, 0, 0);
    for (int f = 0; f < 6; f++) begin
      step(88, 20, 1, 0, 0, 0);
      step(64, 20, 0, 0, 0, 0);
    end

    // loss and new game together
    step(40, 16, 0, 1, 1, 0);
    step(112, 20, 0, 0, 0, 0);

    // drain all lives, reach game over, then extra loss
    for (int n = 0; n < MAXL; n++) begin
      step(16, 16, 0, 1, 0, 0);
      for (int f = 0; f < 60; f++) step(16 + f, 20, 1, 0, 0, 0);
    end
    step(16, 16, 0, 1, 0, 0);
    step(16, 16, 1, 0, 0, 0);

    // reset in the middle of a blink
    step(16, 16, 0, 0, 1, 0);
    step(16, 16, 0, 1, 0, 0);
    for (int f = 0; f < 5; f++) step(112, 20, 1, 0, 0, 0);
    step(112, 20, 0, 0, 0, 1);
    step(112, 20, 0, 0, 0, 0);

    for (int i = 0; i < 20000; i++) rand_step(70, 900, 5000);

    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
